bus_loader: RTL and testbench

- Byte-stream command engine that acts as a second initiator on the 6502-style system bus (AB/DO/WE out, DI in).
- It loads and inspects memory over the serial link while the CPU is held off the bus.
- It sits between a byte-level UART receive/transmit pair and the SoC address decode / data mux, arbitrated by bus_own.
- It holds the CPU from reset until a Go command arrives, which makes it the boot path for RAM images.

---
 rtl/bus_loader_if.sv | 22 ++
 rtl/bus_loader.sv | 130 +++++++++++++
 tb/tb_bus_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bus_loader_if.sv
// bus_loader_if: serial byte link and 6502-style system bus as seen by the loader
interface bus_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        bus_own;
   logic [15:0] bus_ab;
   logic [7:0]  bus_do;
   logic        bus_we;
   logic [7:0]  bus_di;
   logic        cpu_hold;
   modport master (
      input  rx_data, rx_valid, tx_ready, bus_di,
      output tx_data, tx_valid, bus_own, bus_ab, bus_do, bus_we, cpu_hold
   );
   modport slave (
      output rx_data, rx_valid, tx_ready, bus_di,
      input  tx_data, tx_valid, bus_own, bus_ab, bus_do, bus_we, cpu_hold
   );
endinterface

// File: rtl/bus_loader.sv
// bus_loader: serial command engine that loads/inspects memory as a second bus initiator
module bus_loader #(
   parameter logic [23:0] TIMEOUT   = 24'd4000000,
   parameter int          BOOT_HOLD = 1
) (
   input  logic          clk,
   input  logic          reset,
   bus_loader_if.master  io
);
   typedef enum logic [3:0] {
      IDLE, ADH, ADL, LEN, WDATA, WBUS, RADDR, RWAIT, RSEND, RESP
   } state_t;
   state_t      state;
   logic        is_wr;
   logic [15:0] addr;
   logic [15:0] addr_nx;
   logic [8:0]  cnt;
   logic [23:0] tmo;
   logic [7:0]  rx;
   logic        in_frame;
   logic        expired;
   assign rx       = io.rx_data;
   assign addr_nx  = addr + 16'd1;
   assign in_frame = state inside {ADH, ADL, LEN, WDATA};
   assign expired  = in_frame && !io.rx_valid && tmo == TIMEOUT - 24'd1;
   // frame parser, bus sequencer and response path; all outputs registered
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         is_wr       <= 1'b0;
         addr        <= 16'd0;
         cnt         <= 9'd0;
         tmo         <= 24'd0;
         io.bus_own  <= 1'b0;
         io.bus_ab   <= 16'd0;
         io.bus_do   <= 8'd0;
         io.bus_we   <= 1'b0;
         io.tx_valid <= 1'b0;
         io.tx_data  <= 8'd0;
         io.cpu_hold <= (BOOT_HOLD != 0);
      end else begin
         io.bus_we <= 1'b0;
         tmo       <= (in_frame && !io.rx_valid) ? tmo + 24'd1 : 24'd0;
         case (state)
            IDLE: if (io.rx_valid) begin
               is_wr <= rx == 8'h57;
               if (rx == 8'h57 || rx == 8'h52) state <= ADH;
               else begin
                  state       <= RESP;
                  io.tx_valid <= 1'b1;
                  io.tx_data  <= (rx == 8'h47 || rx == 8'h48) ? 8'h2E : 8'h3F;
                  if (rx == 8'h47) io.cpu_hold <= 1'b0;
                  if (rx == 8'h48) io.cpu_hold <= 1'b1;
               end
            end
            ADH: if (io.rx_valid) begin
               addr[15:8] <= rx;
               state      <= ADL;
            end
            ADL: if (io.rx_valid) begin
               addr[7:0] <= rx;
               state     <= LEN;
            end
            LEN: if (io.rx_valid) begin
               cnt <= {rx == 8'd0, rx};
               if (is_wr) state <= WDATA;
               else if (io.cpu_hold) begin
                  state      <= RADDR;
                  io.bus_own <= 1'b1;
                  io.bus_ab  <= addr;
               end else begin
                  state       <= RESP;
                  io.tx_valid <= 1'b1;
                  io.tx_data  <= 8'h21;
               end
            end
            WDATA: if (io.rx_valid) begin
               if (io.cpu_hold) begin
                  state      <= WBUS;
                  io.bus_own <= 1'b1;
                  io.bus_we  <= 1'b1;
                  io.bus_ab  <= addr;
                  io.bus_do  <= rx;
               end else begin
                  cnt <= cnt - 9'd1;
                  if (cnt == 9'd1) begin
                     state       <= RESP;
                     io.tx_valid <= 1'b1;
                     io.tx_data  <= 8'h21;
                  end
               end
            end
            WBUS: begin
               io.bus_own <= 1'b0;
               addr       <= addr_nx;
               cnt        <= cnt - 9'd1;
               if (cnt == 9'd1) begin
                  state       <= RESP;
                  io.tx_valid <= 1'b1;
                  io.tx_data  <= 8'h2E;
               end else state <= WDATA;
            end
            RADDR: state <= RWAIT;
            RWAIT: begin
               io.tx_data  <= io.bus_di;
               io.tx_valid <= 1'b1;
               state       <= RSEND;
            end
            RSEND: if (io.tx_ready) begin
               io.tx_valid <= 1'b0;
               addr        <= addr_nx;
               cnt         <= cnt - 9'd1;
               if (cnt == 9'd1) begin
                  state      <= IDLE;
                  io.bus_own <= 1'b0;
               end else begin
                  state     <= RADDR;
                  io.bus_ab <= addr_nx;
               end
            end
            RESP: if (io.tx_ready) begin
               io.tx_valid <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (expired) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_bus_loader.sv
// tb_bus_loader: directed checks of the serial bus loader against a 1-cycle-latency memory
module tb_bus_loader;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   passed = 0;
   int   total = 0;
   int   dly = 0;
   int   vcnt = 0;
   int   unstable = 0;
   int   we_viol = 0;
   int   we_multi = 0;
   int   own_seen = 0;
   int   errs;
   logic prev_v = 1'b0;
   logic prev_r = 1'b0;
   logic prev_we = 1'b0;
   logic [7:0] prev_d = 8'd0;
   logic [7:0] mem [0:65535];
   logic [7:0] mem_q = 8'd0;
   logic [7:0] txq [$];
   logic [23:0] weq [$];
   logic [7:0] exp_b;
   bus_loader_if io();
   bus_loader #(.TIMEOUT(24'd40), .BOOT_HOLD(1)) dut (.clk(clk), .reset(reset), .io(io));
   always #5 clk = ~clk;
   // host transmitter accepts after dly cycles of tx_valid
   assign io.tx_ready = io.tx_valid && vcnt >= dly;
   always @(posedge clk) vcnt <= (io.tx_valid && !io.tx_ready) ? vcnt + 1 : 0;
   // memory with registered read data
   assign io.bus_di = mem_q;
   always @(posedge clk) begin
      if (io.bus_we) mem[io.bus_ab] <= io.bus_do;
      mem_q <= mem[io.bus_ab];
   end
   // mid-cycle monitor for bus writes and transmitted bytes
   always @(negedge clk) begin
      if (io.bus_we) begin
         weq.push_back({io.bus_ab, io.bus_do});
         if (!io.bus_own) we_viol++;
         if (prev_we) we_multi++;
      end
      prev_we = io.bus_we;
      if (io.bus_own) own_seen = 1;
      if (prev_v && !prev_r && (!io.tx_valid || io.tx_data !== prev_d)) unstable++;
      if (io.tx_valid && io.tx_ready) txq.push_back(io.tx_data);
      prev_v = io.tx_valid;
      prev_r = io.tx_ready;
      prev_d = io.tx_data;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input logic [7:0] b);
      io.rx_data  = b;
      io.rx_valid = 1'b1;
      cyc(1);
      io.rx_valid = 1'b0;
      cyc(3);
   endtask
   task automatic wait_tx(input int n, input int budget, input string tag);
      int c = 0;
      while (txq.size() < n && c < budget) begin
         cyc(1);
         c++;
      end
      chk(tag, txq.size(), n);
   endtask
   task automatic clr();
      txq.delete();
      weq.delete();
      own_seen = 0;
   endtask
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ 8'h5A;
      io.rx_data  = 8'd0;
      io.rx_valid = 1'b0;
      cyc(3);
      chk("rst_hold", io.cpu_hold, 1);
      chk("rst_own", io.bus_own, 0);
      chk("rst_txv", io.tx_valid, 0);
      chk("rst_txd", io.tx_data, 0);
      chk("rst_ab", io.bus_ab, 0);
      reset = 1'b1;
      cyc(2);
      clr();
      send(8'h47);
      wait_tx(1, 20, "go_cnt");
      chk("go_tx", txq[0], 8'h2E);
      chk("go_hold", io.cpu_hold, 0);
      clr();
      send(8'h48);
      wait_tx(1, 20, "halt_cnt");
      chk("halt_tx", txq[0], 8'h2E);
      chk("halt_hold", io.cpu_hold, 1);
      clr();
      send(8'h57); send(8'h02); send(8'h00); send(8'h03);
      send(8'hA9); send(8'h01); send(8'h60);
      wait_tx(1, 20, "wr_ack_cnt");
      chk("wr_ack", txq[0], 8'h2E);
      chk("wr_cnt", weq.size(), 3);
      chk("wr0", weq[0], 24'h0200A9);
      chk("wr1", weq[1], 24'h020101);
      chk("wr2", weq[2], 24'h020260);
      chk("wr_single", we_multi, 0);
      clr();
      dly = 5;
      send(8'h52); send(8'h02); send(8'h00); send(8'h02);
      wait_tx(2, 100, "rd_cnt");
      cyc(20);
      chk("rd_noack", txq.size(), 2);
      chk("rd0", txq[0], 8'hA9);
      chk("rd1", txq[1], 8'h01);
      chk("rd_stable", unstable, 0);
      chk("rd_own_seen", own_seen, 1);
      chk("rd_own_end", io.bus_own, 0);
      dly = 0;
      clr();
      send(8'h57); send(8'hFF); send(8'hFF); send(8'h02); send(8'h11); send(8'h22);
      wait_tx(1, 20, "wrap_ack_cnt");
      chk("wrap_ack", txq[0], 8'h2E);
      chk("wrap_cnt", weq.size(), 2);
      chk("wrap0", weq[0], 24'hFFFF11);
      chk("wrap1", weq[1], 24'h000022);
      clr();
      send(8'h52); send(8'h00); send(8'h00); send(8'h00);
      wait_tx(256, 2000, "rd256_cnt");
      cyc(20);
      chk("rd256_exact", txq.size(), 256);
      errs = 0;
      for (int i = 0; i < 256 && i < txq.size(); i++) begin
         exp_b = (i == 0) ? 8'h22 : (i[7:0] ^ 8'h5A);
         if (txq[i] !== exp_b) errs++;
      end
      chk("rd256_first", txq[0], 8'h22);
      chk("rd256_second", txq[1], 8'h5B);
      chk("rd256_data", errs, 0);
      clr();
      send(8'h57); send(8'h10);
      cyc(60);
      chk("to_notx", txq.size(), 0);
      chk("to_txv", io.tx_valid, 0);
      chk("to_own", io.bus_own, 0);
      chk("to_nowe", weq.size(), 0);
      send(8'h5A);
      wait_tx(1, 20, "to_z_cnt");
      chk("to_z", txq[0], 8'h3F);
      clr();
      send(8'h47);
      wait_tx(1, 20, "go2_cnt");
      chk("go2_hold", io.cpu_hold, 0);
      clr();
      send(8'h57); send(8'h00); send(8'h00); send(8'h01); send(8'h55);
      wait_tx(1, 20, "deny_w_cnt");
      chk("deny_w_tx", txq[0], 8'h21);
      chk("deny_w_we", weq.size(), 0);
      chk("deny_w_own", own_seen, 0);
      clr();
      send(8'h52); send(8'h00); send(8'h00); send(8'h01);
      wait_tx(1, 20, "deny_r_cnt");
      chk("deny_r_tx", txq[0], 8'h21);
      chk("deny_r_own", own_seen, 0);
      clr();
      send(8'h52); send(8'h02);
      reset = 1'b0;
      cyc(2);
      chk("mid_rst_hold", io.cpu_hold, 1);
      chk("mid_rst_own", io.bus_own, 0);
      chk("mid_rst_txv", io.tx_valid, 0);
      chk("mid_rst_txd", io.tx_data, 0);
      chk("mid_rst_we", io.bus_we, 0);
      reset = 1'b1;
      cyc(20);
      chk("mid_rst_notx", txq.size(), 0);
      send(8'h00);
      wait_tx(1, 20, "mid_rst_idle_cnt");
      chk("mid_rst_idle", txq[0], 8'h3F);
      chk("we_owned", we_viol, 0);
      chk("tx_stable_all", unstable, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end
endmodule
